// File: rtl/tone_digit_collector.sv
// Debounces one-hot tone reports into key codes and queues them in a FWFT FIFO.
// Optional TONE_DIGIT_ASCII_EN stores and presents ASCII characters instead of 4-bit key codes.
module tone_digit_collector #(
  parameter int MIN_HITS   = 3,
  parameter int MIN_GAP    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          done,
  input  logic [15:0]                   Tone,
  input  logic                          rd_en,
  output logic [7:0]                    digit_out,
  output logic                          digit_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          bad_tone
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned HW = $clog2(MIN_HITS + 1);
  localparam int unsigned GW = $clog2(MIN_GAP + 1);
`ifdef TONE_DIGIT_ASCII_EN
  localparam int unsigned DW = 8;
`else
  localparam int unsigned DW = 4;
`endif

  localparam logic [HW-1:0] HIT_LAST = HW'(MIN_HITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ARMED, CAND, HELD} state_t;

  state_t        state;
  logic [3:0]    cand;
  logic [HW-1:0] hit_cnt;
  logic [GW-1:0] gap_cnt;

  logic          det;
  logic          one_hot;
  logic          multi;
  logic          valid;
  logic [3:0]    code;
  logic          push;
  logic [DW-1:0] push_data;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          wr_ok;
  logic          rd_ok;

  // clear outranks detections, so a detection is never seen in a clear cycle
  assign det     = done & enable & ~clear;
  assign one_hot = (Tone != '0) && ((Tone & (Tone - 16'd1)) == '0);
  assign multi   = (Tone != '0) && !one_hot;
  assign valid   = det & one_hot;

  always_comb begin
    code = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (Tone[i]) code = 4'(i);
    end
  end

  always_comb begin
    push = 1'b0;
    case (state)
      ARMED:   push = valid && (MIN_HITS == 1);
      CAND:    push = valid && (code == cand) && (hit_cnt == HIT_LAST);
      default: push = 1'b0;
    endcase
  end

`ifdef TONE_DIGIT_ASCII_EN
  function automatic logic [7:0] to_ascii(input logic [3:0] k);
    case (k)
      4'd0:    to_ascii = 8'h31;
      4'd1:    to_ascii = 8'h32;
      4'd2:    to_ascii = 8'h33;
      4'd3:    to_ascii = 8'h41;
      4'd4:    to_ascii = 8'h34;
      4'd5:    to_ascii = 8'h35;
      4'd6:    to_ascii = 8'h36;
      4'd7:    to_ascii = 8'h42;
      4'd8:    to_ascii = 8'h37;
      4'd9:    to_ascii = 8'h38;
      4'd10:   to_ascii = 8'h39;
      4'd11:   to_ascii = 8'h43;
      4'd12:   to_ascii = 8'h2A;
      4'd13:   to_ascii = 8'h30;
      4'd14:   to_ascii = 8'h23;
      default: to_ascii = 8'h44;
    endcase
  endfunction

  assign push_data = to_ascii(cand == code ? cand : code);
  assign digit_out = digit_valid ? mem[rd_ptr] : '0;
`else
  assign push_data = (cand == code) ? cand : code;
  assign digit_out = digit_valid ? {4'h0, mem[rd_ptr]} : '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARMED;
      cand     <= '0;
      hit_cnt  <= '0;
      gap_cnt  <= '0;
      bad_tone <= 1'b0;
    end else begin
      bad_tone <= det & multi;
      if (clear) begin
        state   <= ARMED;
        cand    <= '0;
        hit_cnt <= '0;
        gap_cnt <= '0;
      end else if (det) begin
        case (state)
          ARMED: begin
            if (valid) begin
              cand    <= code;
              hit_cnt <= HW'(1);
              gap_cnt <= '0;
              state   <= (MIN_HITS == 1) ? HELD : CAND;
            end
          end
          CAND: begin
            if (!valid) begin
              state   <= ARMED;
              hit_cnt <= '0;
            end else if (code == cand) begin
              hit_cnt <= hit_cnt + HW'(1);
              if (push) begin
                state   <= HELD;
                gap_cnt <= '0;
              end
            end else begin
              cand    <= code;
              hit_cnt <= HW'(1);
            end
          end
          HELD: begin
            // a re-arming detection never seeds a candidate, even if it is VALID
            if (valid && (code == cand)) begin
              gap_cnt <= '0;
            end else if (gap_cnt == GAP_LAST) begin
              state   <= ARMED;
              gap_cnt <= '0;
              hit_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: state <= ARMED;
        endcase
      end
    end
  end

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign digit_valid = ~empty;
  // when full, a same-cycle pop frees the slot the push is written into
  assign wr_ok       = push & (~full | rd_en);
  assign rd_ok       = rd_en & ~empty & ~clear;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      if (push & full & ~rd_en) overflow <= 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/tone_digit_collector.md
# tone_digit_collector

Downstream consumer of the tone detector's `done`/`Tone` output. Converts each one-hot tone report into a key code, debounces it (a key must repeat on consecutive detections to be accepted, then must be released before it can repeat), and queues accepted keys in a small first-word-fall-through FIFO. The processor-side logic drains the FIFO with a read strobe.

## Interface
- `MIN_HITS`, 3: consecutive identical valid detections needed to accept a key (≥1)
- `MIN_GAP`, 2: consecutive non-matching detections needed to re-arm after acceptance (≥1)
- `FIFO_DEPTH`, 8: queue entries, power of two (≥2)

- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high reset
- `enable` input 1: when low, `done` is ignored; FIFO reads still serviced
- `clear` input 1: synchronous flush; empties FIFO, clears `overflow`, FSM to ARMED
- `done` input 1: one-cycle pulse, `Tone` valid this cycle
- `Tone` input 16: one-hot key; 0 = no tone
- `rd_en` input 1: pop head entry
- `digit_out` output 8: head entry (see Configuration)
- `digit_valid` output 1: FIFO non-empty
- `count` output $clog2(FIFO_DEPTH)+1: entries held
- `overflow` output 1: sticky; an accepted key was dropped because FIFO full
- `bad_tone` output 1: one-cycle pulse; `Tone` had >1 bit set on a sampled `done`

## Operation
- Tone bit→code (code = bit index): 0 '1', 1 '2', 2 '3', 3 'A', 4 '4', 5 '5', 6 '6', 7 'B', 8 '7', 9 '8', 10 '9', 11 'C', 12 '*', 13 '0', 14 '#', 15 'D'.
- A detection is a cycle with `done & enable`. It is classified as VALID(k) (exactly one bit set) or NONE (zero bits, or >1 bit; >1 bit also pulses `bad_tone`).
- FSM states: ARMED, CAND, HELD. Registers: `cand[3:0]`, `hit_cnt`, `gap_cnt`.
- ARMED: VALID(k) → cand=k, hit_cnt=1, go to CAND; if MIN_HITS==1, push k and go to HELD. NONE → stay.
- CAND: VALID(cand) → hit_cnt+1; on reaching MIN_HITS, push cand, gap_cnt=0, go to HELD. VALID(j≠cand) → cand=j, hit_cnt=1. NONE → ARMED.
- HELD: VALID(cand) → gap_cnt=0. NONE or VALID(j≠cand) → gap_cnt+1; on reaching MIN_GAP, go to ARMED. The triggering detection does not seed a new candidate.
- No detection: FSM holds all state, with no timeout.
- FIFO push and pop:
  - push with FIFO not full → write.
  - push with FIFO full and no `rd_en` → drop the entry and set `overflow`.
  - push + `rd_en` with FIFO full → both succeed; count unchanged.
  - `rd_en` with FIFO empty → ignored; a simultaneous push still writes.
- Pointers wrap modulo FIFO_DEPTH.
- `clear` has priority over push/pop and over detections in the same cycle.

## Timing
- Reset values: `digit_out`=0, `digit_valid`=0, `count`=0, `overflow`=0, `bad_tone`=0; FSM ARMED; counters 0; pointers 0.
- A detection sampled at edge E updates FSM, FIFO and `overflow` at E. `digit_valid`/`count` reflect the push immediately after E, so latency is 1 clock from the accepting `done`.
- `digit_out` is combinational from head memory and is valid whenever `digit_valid`=1. It is 0 when empty.
- `rd_en` sampled at edge E advances the head at E; the next entry is visible after E.
- `bad_tone` is registered: high for the one cycle after the offending `done` edge.
- Reset asserted mid-sequence discards candidate and FIFO contents immediately (asynchronous).

## Configuration
- `TONE_DIGIT_ASCII_EN` defined: `digit_out` = ASCII of the key ('0'–'9' = 0x30–0x39, 'A'–'D' = 0x41–0x44, '*' = 0x2A, '#' = 0x23). Conversion happens before the FIFO write, so the FIFO is 8 bits wide.
- Not defined: `digit_out[7:4]`=0, `digit_out[3:0]`=key code; FIFO is 4 bits wide.

## Test plan
- Defaults, `Tone`=0x0020 on 3 `done` pulses → after 3rd pulse +1 clk, `digit_valid`=1, `count`=1, `digit_out`=0x05 (0x35 with ASCII_EN).
- 0x0020, 0x0020, 0x0000, 0x0020×3 → no push until 6th pulse; exactly one entry.
- Key held for 10 pulses, then 0x0000×2, then the same key ×3 → exactly two entries; a single 0x0000 between holds yields one entry.
- `Tone`=0x0003 on `done` → `bad_tone` high one cycle, FSM returns/stays ARMED, no push.
- Fill 8 entries, accept a 9th → `overflow`=1, `count`=8, head unchanged. 9th accept with `rd_en` same cycle → `count`=8, `overflow` stays 0. `clear` → `count`=0, `overflow`=0.
- Assert `reset` in CAND with hit_cnt=2, deassert, send 1 more matching pulse → no push (restarted at hit_cnt=1). `enable`=0 pulses → no state change.
